// File: rtl/i2c_reg_ctrl_pkg.sv
// Shared constants for the I2C register-bank controller: FSM encodings and
// default geometry.
package i2c_reg_ctrl_pkg;

  localparam int DEF_NREG = 16;
  localparam int DEF_AW   = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_ADDR_SKIP = 3'd1;
  localparam state_t ST_PTR       = 3'd2;
  localparam state_t ST_DATA      = 3'd3;
  localparam state_t ST_RD_HOLD   = 3'd4;

endpackage

// File: rtl/i2c_reg_ctrl_if.sv
// Byte stream from the I2C slave plus the local host write port.
interface i2c_reg_ctrl_if #(parameter int AW = i2c_reg_ctrl_pkg::DEF_AW);

  logic [7:0]    in_data;
  logic          in_ena;
  logic          in_ready;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdata;
  logic          host_ack;

  modport master (
    output in_data, in_ena, in_ready, host_we, host_addr, host_wdata,
    input  host_ack
  );

  modport slave (
    input  in_data, in_ena, in_ready, host_we, host_addr, host_wdata,
    output host_ack
  );

endinterface

// File: rtl/i2c_edge_sync.sv
// Registers the slave idle flag; falling edge marks transfer start, rising
// edge marks stop. Resetting the flop low means a low in_ready is never a start
// until it has been seen high.
module i2c_edge_sync (
  input  logic clk,
  input  logic n_rst,
  input  logic in_ready,
  output logic start,
  output logic stop
);

  logic ready_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) ready_q <= 1'b0;
    else        ready_q <= in_ready;
  end

  assign start = ready_q & ~in_ready;
  assign stop  = ~ready_q & in_ready;

endmodule

// File: rtl/i2c_reg_ctrl.sv
// Register bank behind an I2C slave: pointer byte then auto-incrementing
// writes, host write port at lower priority, commit pulse at stop.
module i2c_reg_ctrl
  import i2c_reg_ctrl_pkg::*;
#(
  parameter int         NREG    = DEF_NREG,
  parameter int         AW      = DEF_AW,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic            clk,
  input  logic            n_rst,
  i2c_reg_ctrl_if.slave   bus,
  output logic [NREG*8-1:0] regs_flat,
  output logic            wr_strobe,
  output logic [AW-1:0]   wr_addr,
  output logic [7:0]      rd_data,
  output logic            rw_flag,
  output logic            cfg_update,
  output logic            ptr_err
);

  logic          start;
  logic          stop;
  state_t        state;
  logic [AW-1:0] ptr;
  logic          wrote;
  logic          ptr_oor;
  logic [7:0]    regs [NREG];

  logic i2c_byte;
  logic ptr_ok;
  logic i2c_wr;
  logic host_go;
  logic host_ok;

  i2c_edge_sync u_edge (
    .clk      (clk),
    .n_rst    (n_rst),
    .in_ready (bus.in_ready),
    .start    (start),
    .stop     (stop)
  );

  // ptr_oor covers pointer bytes above the AW-bit range that truncate back in range
  assign ptr_ok   = (int'(ptr) < NREG) && !ptr_oor;
  assign i2c_byte = bus.in_ena && (state == ST_DATA);
  assign i2c_wr   = i2c_byte && ptr_ok;
  assign host_go  = bus.host_we && !i2c_wr;
  assign host_ok  = int'(bus.host_addr) < NREG;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      wrote        <= 1'b0;
      ptr_oor      <= 1'b0;
      ptr_err      <= 1'b0;
      rw_flag      <= 1'b0;
      cfg_update   <= 1'b0;
      wr_strobe    <= 1'b0;
      wr_addr      <= '0;
      bus.host_ack <= 1'b0;
    end else begin
      wr_strobe    <= i2c_wr || (host_go && host_ok);
      wr_addr      <= i2c_wr ? ptr : bus.host_addr;
      bus.host_ack <= host_go;
      cfg_update   <= stop && (state != ST_IDLE) && (wrote || i2c_wr);

      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_ADDR_SKIP;
            ptr_err <= 1'b0;
            wrote   <= 1'b0;
            ptr_oor <= 1'b0;
          end
        end
        ST_ADDR_SKIP: begin
          if (bus.in_ena) begin
            rw_flag <= bus.in_data[0];
            state   <= bus.in_data[0] ? ST_RD_HOLD : ST_PTR;
          end
        end
        ST_PTR: begin
          if (bus.in_ena) begin
            ptr     <= bus.in_data[AW-1:0];
            ptr_oor <= int'(bus.in_data) >= NREG;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bus.in_ena) begin
            if (ptr_ok) begin
              wrote <= 1'b1;
              if (int'(ptr) == NREG - 1) ptr <= '0;
              else                       ptr <= ptr + AW'(1);
            end else begin
              ptr_err <= 1'b1;
            end
          end
        end
        ST_RD_HOLD: ;
        default: state <= ST_IDLE;
      endcase

      // A byte arriving with stop has already been handled above
      if (stop && (state != ST_IDLE)) state <= ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= RST_VAL;
    end else if (i2c_wr) begin
      regs[ptr] <= bus.in_data;
    end else if (host_go && host_ok) begin
      regs[bus.host_addr] <= bus.host_wdata;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = regs[g];
  end

  assign rd_data = (int'(ptr) < NREG) ? regs[ptr] : 8'hFF;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Self-checking bench: a 16-register and a 12-register controller driven by the
// same byte stream; write scoreboard on the 16-register instance.
module tb_i2c_reg_ctrl;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] in_data;
  logic       in_ena;
  logic       in_ready;
  logic       host_we;
  logic [3:0] host_addr;
  logic [7:0] host_wdata;

  i2c_reg_ctrl_if #(.AW(4)) bus_a ();
  i2c_reg_ctrl_if #(.AW(4)) bus_b ();

  assign bus_a.in_data    = in_data;
  assign bus_a.in_ena     = in_ena;
  assign bus_a.in_ready   = in_ready;
  assign bus_a.host_we    = host_we;
  assign bus_a.host_addr  = host_addr;
  assign bus_a.host_wdata = host_wdata;
  assign bus_b.in_data    = in_data;
  assign bus_b.in_ena     = in_ena;
  assign bus_b.in_ready   = in_ready;
  assign bus_b.host_we    = host_we;
  assign bus_b.host_addr  = host_addr;
  assign bus_b.host_wdata = host_wdata;

  logic [127:0] regs_a;
  logic         wr_strobe_a, rw_flag_a, cfg_a, ptr_err_a;
  logic [3:0]   wr_addr_a;
  logic [7:0]   rd_data_a;
  logic [95:0]  regs_b;
  logic         wr_strobe_b, rw_flag_b, cfg_b, ptr_err_b;
  logic [3:0]   wr_addr_b;
  logic [7:0]   rd_data_b;

  i2c_reg_ctrl #(.NREG(16), .AW(4), .RST_VAL(8'h00)) dut_a (
    .clk(clk), .n_rst(n_rst), .bus(bus_a), .regs_flat(regs_a),
    .wr_strobe(wr_strobe_a), .wr_addr(wr_addr_a), .rd_data(rd_data_a),
    .rw_flag(rw_flag_a), .cfg_update(cfg_a), .ptr_err(ptr_err_a)
  );

  i2c_reg_ctrl #(.NREG(12), .AW(4), .RST_VAL(8'h00)) dut_b (
    .clk(clk), .n_rst(n_rst), .bus(bus_b), .regs_flat(regs_b),
    .wr_strobe(wr_strobe_b), .wr_addr(wr_addr_b), .rd_data(rd_data_b),
    .rw_flag(rw_flag_b), .cfg_update(cfg_b), .ptr_err(ptr_err_b)
  );

  int checks = 0;
  int passed = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t sb[$];
  wr_t sb_e;

  always @(negedge clk) begin
    if (n_rst && wr_strobe_a) begin
      if (sb.size() == 0) begin
        checks++;
        $display("[TB] FAIL sb_unexpected: wr_strobe at addr %0d, expected no write", wr_addr_a);
      end else begin
        sb_e = sb.pop_front();
        checkOutput("sb_addr", 128'(wr_addr_a), 128'(sb_e.addr));
        checkOutput("sb_data", 128'(regs_a[8*sb_e.addr +: 8]), 128'(sb_e.data));
      end
    end
  end

  int cfg_cnt_a = 0;
  int cfg_cnt_b = 0;
  always @(negedge clk) begin
    if (cfg_a) cfg_cnt_a++;
    if (cfg_b) cfg_cnt_b++;
  end

  typedef struct {
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [3:0] a0;
    logic [3:0] a1;
  } vec_t;

  vec_t       vecs [4];
  logic [7:0] exp_a [16];
  int         cfg_exp_a = 0;

  function automatic logic [127:0] flatA();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = exp_a[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    in_data = b;
    in_ena  = 1'b1;
    tick();
    in_ena  = 1'b0;
    tick();
  endtask

  task automatic startXfer();
    in_ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic stopXfer();
    in_ready = 1'b1;
    tick();
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{8'h03, 8'h11, 8'h22, 4'd3,  4'd4};
    vecs[1] = '{8'h0F, 8'hAA, 8'hBB, 4'd15, 4'd0};
    vecs[2] = '{8'h07, 8'h3C, 8'h4D, 4'd7,  4'd8};
    vecs[3] = '{8'h05, 8'h5A, 8'hC3, 4'd5,  4'd6};
    for (int i = 0; i < 16; i++) exp_a[i] = 8'h00;

    in_data = '0; in_ena = 1'b0; in_ready = 1'b1;
    host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) tick();
    n_rst = 1'b1;
    tick();
    tick();

    checkOutput("rst_regs_a", regs_a, 128'h0);
    checkOutput("rst_regs_b", 128'(regs_b), 128'h0);
    checkOutput("rst_ptr_err", 128'(ptr_err_a), 128'h0);
    checkOutput("rst_rw_flag", 128'(rw_flag_a), 128'h0);
    checkOutput("rst_host_ack", 128'(bus_a.host_ack), 128'h0);
    checkOutput("rst_wr_strobe", 128'(wr_strobe_a), 128'h0);
    checkOutput("rst_cfg", 128'(cfg_cnt_a), 128'h0);

    for (int i = 0; i < 4; i++) begin
      startXfer();
      applyStimulus(8'hA0);
      applyStimulus(vecs[i].ptr);
      sb.push_back('{vecs[i].a0, vecs[i].d0});
      exp_a[vecs[i].a0] = vecs[i].d0;
      applyStimulus(vecs[i].d0);
      sb.push_back('{vecs[i].a1, vecs[i].d1});
      exp_a[vecs[i].a1] = vecs[i].d1;
      applyStimulus(vecs[i].d1);
      stopXfer();
      cfg_exp_a++;
      checkOutput($sformatf("vec%0d_cfg", i), 128'(cfg_cnt_a), 128'(cfg_exp_a));
      checkOutput($sformatf("vec%0d_ptr_err", i), 128'(ptr_err_a), 128'h0);
      checkOutput($sformatf("vec%0d_reg_a0", i), 128'(regs_a[8*vecs[i].a0 +: 8]), 128'(vecs[i].d0));
      checkOutput($sformatf("vec%0d_reg_a1", i), 128'(regs_a[8*vecs[i].a1 +: 8]), 128'(vecs[i].d1));
    end

    // Read transfer: pointer left at 7 by the last write
    startXfer();
    applyStimulus(8'hA1);
    checkOutput("rd_rw_flag", 128'(rw_flag_a), 128'h1);
    checkOutput("rd_data", 128'(rd_data_a), 128'h3C);
    stopXfer();
    checkOutput("rd_no_cfg", 128'(cfg_cnt_a), 128'(cfg_exp_a));

    // Host write colliding with an I2C write to reg 5
    startXfer();
    applyStimulus(8'hA0);
    applyStimulus(8'h05);
    sb.push_back('{4'd5, 8'h99});
    sb.push_back('{4'd5, 8'h77});
    exp_a[5] = 8'h77;
    in_data = 8'h99; in_ena = 1'b1;
    host_we = 1'b1; host_addr = 4'd5; host_wdata = 8'h77;
    tick();
    in_ena = 1'b0;
    checkOutput("col_ack_blocked", 128'(bus_a.host_ack), 128'h0);
    checkOutput("col_i2c_first", 128'(regs_a[8*5 +: 8]), 128'h99);
    tick();
    checkOutput("col_ack_granted", 128'(bus_a.host_ack), 128'h1);
    host_we = 1'b0;
    tick();
    checkOutput("col_final_reg5", 128'(regs_a[8*5 +: 8]), 128'h77);
    stopXfer();
    cfg_exp_a++;
    checkOutput("col_cfg", 128'(cfg_cnt_a), 128'(cfg_exp_a));

    // Host write beyond the 12-register bank: acked, no strobe there
    sb.push_back('{4'd13, 8'h66});
    exp_a[13] = 8'h66;
    host_we = 1'b1; host_addr = 4'd13; host_wdata = 8'h66;
    tick();
    checkOutput("host_oor_ack_b", 128'(bus_b.host_ack), 128'h1);
    checkOutput("host_oor_strobe_b", 128'(wr_strobe_b), 128'h0);
    checkOutput("host_ack_a", 128'(bus_a.host_ack), 128'h1);
    host_we = 1'b0;
    tick();
    checkOutput("host_no_cfg", 128'(cfg_cnt_a), 128'(cfg_exp_a));

    // Reset in the middle of a write transfer
    startXfer();
    applyStimulus(8'hA0);
    applyStimulus(8'h04);
    n_rst = 1'b0;
    for (int i = 0; i < 16; i++) exp_a[i] = 8'h00;
    tick();
    tick();
    checkOutput("midrst_regs_a", regs_a, 128'h0);
    checkOutput("midrst_regs_b", 128'(regs_b), 128'h0);
    n_rst = 1'b1;
    tick();
    tick();
    applyStimulus(8'h42);
    in_ready = 1'b1;
    tick();
    tick();
    checkOutput("midrst_no_cfg", 128'(cfg_cnt_a), 128'(cfg_exp_a));
    startXfer();
    applyStimulus(8'hA0);
    applyStimulus(8'h02);
    sb.push_back('{4'd2, 8'h44});
    exp_a[2] = 8'h44;
    applyStimulus(8'h44);
    stopXfer();
    cfg_exp_a++;
    checkOutput("postrst_cfg", 128'(cfg_cnt_a), 128'(cfg_exp_a));
    checkOutput("postrst_regs_a", regs_a, flatA());

    // Out-of-range pointer on the 12-register instance
    cfg_cnt_b = 0;
    startXfer();
    applyStimulus(8'hA0);
    applyStimulus(8'h0E);
    checkOutput("oor_rd_data_b", 128'(rd_data_b), 128'hFF);
    sb.push_back('{4'd14, 8'h55});
    exp_a[14] = 8'h55;
    applyStimulus(8'h55);
    checkOutput("oor_ptr_err_b", 128'(ptr_err_b), 128'h1);
    checkOutput("oor_ptr_err_a", 128'(ptr_err_a), 128'h0);
    stopXfer();
    cfg_exp_a++;
    checkOutput("oor_cfg_b", 128'(cfg_cnt_b), 128'h0);
    checkOutput("oor_regs_b", 128'(regs_b), 128'h0000_0000_0000_0000_0044_0000);
    checkOutput("oor_sticky_b", 128'(ptr_err_b), 128'h1);
    startXfer();
    checkOutput("oor_cleared_b", 128'(ptr_err_b), 128'h0);
    applyStimulus(8'hA0);
    stopXfer();
    checkOutput("final_cfg_a", 128'(cfg_cnt_a), 128'(cfg_exp_a));
    checkOutput("final_regs_a", regs_a, flatA());
    checkOutput("sb_drained", 128'(sb.size()), 128'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/i2c_reg_ctrl.md
Name: i2c_reg_ctrl

Overview:
Register-bank controller that sits behind the I2C slave and turns its byte stream into addressed register writes. The first byte after the device-address byte is a register pointer; subsequent bytes write consecutive registers with auto-increment. It also arbitrates a local host write port against I2C writes. It drives the read-back byte and a commit pulse at the I2C stop condition for downstream configuration logic.

Parameters:
NREG, 16, number of 8-bit registers (2..256)
AW, 4, pointer width; NREG <= 2**AW
RST_VAL, 8'h00, reset value of every register

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
in_data  in  8  byte from I2C slave (out_data)
in_ena  in  1  byte-valid strobe from slave (out_ena), 1-cycle pulse
in_ready  in  1  slave idle flag (ready); low = transfer in progress
host_we  in  1  local host write request, held until host_ack
host_addr  in  AW  host register address
host_wdata  in  8  host write data
host_ack  out  1  host write accepted this cycle
regs_flat  out  NREG*8  all registers; reg i at [8i+7:8i]
wr_strobe  out  1  pulse: a register was written this cycle, either source
wr_addr  out  AW  address of that write
rd_data  out  8  reg[ptr], or 8'hFF when ptr >= NREG
rw_flag  out  1  R/W bit of the current transfer (1 = read)
cfg_update  out  1  1-cycle pulse at stop if the transfer wrote >= 1 register
ptr_err  out  1  sticky: I2C write attempted at ptr >= NREG; cleared at next transfer start

Behaviour:
- Reset, asynchronous: state=IDLE, all regs=RST_VAL, ptr=0, rw_flag=0, ptr_err=0, host_ack=0, wr_strobe=0, wr_addr=0, cfg_update=0, wrote=0.
- in_ready is registered once; its rising edge is "stop" and its falling edge is "start".
- FSM:
  - IDLE: on start -> ADDR_SKIP; clear ptr_err and wrote.
  - ADDR_SKIP: the first in_ena is the device address byte. Latch rw_flag=in_data[0]. If read -> RD_HOLD, else -> PTR.
  - PTR: on in_ena, ptr <= in_data[AW-1:0]; if in_data >= NREG, ptr is still loaded and ptr_err is armed for the next data byte. -> DATA.
  - DATA: on each in_ena, if ptr < NREG write reg[ptr] <= in_data, set wrote, pulse wr_strobe with wr_addr=ptr; else set ptr_err and perform no write. After each byte, ptr <= ptr+1 when ptr = NREG-1 or below, with ptr = NREG-1 wrapping to 0; ptr >= NREG is not incremented.
  - RD_HOLD: rd_data presented from ptr, which keeps the value from the previous write transfer; no register changes.
  - Any state: stop -> IDLE, and cfg_update pulses in the same cycle if wrote=1. A stop with in_ena in the same cycle processes the byte first, then goes to IDLE.
- Repeated start is not visible (in_ready stays low) and is treated as continuation of the current transfer. The slave-side sequence restarts, so a repeated-start address byte is then taken as data; this is a documented limitation.
- Latency: a register update is visible on regs_flat 1 cycle after in_ena. wr_strobe is asserted in that same cycle.
- Arbitration: an I2C write has priority. A host write happens in a cycle with host_we=1 and no I2C write pending. In that cycle host_ack=1, reg[host_addr] is updated and wr_strobe/wr_addr reflect the host write. On collision host_ack=0; the host holds its request and it is granted the next cycle. host_addr >= NREG is acked but has no effect and no wr_strobe. Host writes never set wrote.
- rd_data is combinational from ptr and the register array.
- Reset mid-transfer aborts it: no cfg_update pulse. After reset, in_ready sampled low does not count as start until it has first been seen high.

Decomposition:
- Shared package: FSM state encodings (IDLE, ADDR_SKIP, PTR, DATA, RD_HOLD) and the default NREG/AW constants.
- One sub-module, i2c_edge_sync: registers in_ready and emits start/stop pulses.

Test Plan:
- Write transfer: addr byte 8'hA0, ptr 8'h03, data 8'h11, 8'h22 -> reg3=8'h11, reg4=8'h22; two wr_strobe pulses with wr_addr 3 then 4; one cfg_update at stop.
- Wrap: ptr 8'h0F, data 8'hAA, 8'hBB (NREG=16) -> reg15=8'hAA, reg0=8'hBB; ptr_err stays 0.
- Out of range: NREG=12, ptr 8'h0E, data 8'h55 -> no register change, ptr_err=1, no cfg_update; next start clears ptr_err.
- Collision: host_we to addr 5 in the same cycle as an I2C write to reg 5 -> I2C value lands first, host_ack=0 that cycle, host_ack=1 next cycle, final reg5 = host_wdata.
- Read transfer: addr byte 8'hA1 after a write that left ptr=7 -> rw_flag=1, rd_data=reg7, no writes, no cfg_update at stop.
- Reset asserted after the ptr byte, mid-transfer -> all regs = RST_VAL, state IDLE, no cfg_update; a following full transfer works normally.
